// File: rtl/rat_fetch_pkg.sv
// Shared fetch-stage definitions: branch opcodes, BHT counter type, decode helpers.
// Instruction layout: opcode = {instr[17:13], instr[1:0]}, branch target = instr[12:3].
package rat_fetch_pkg;

  localparam logic [6:0] OP_BRN  = 7'b0010000;
  localparam logic [6:0] OP_CALL = 7'b0010001;
  localparam logic [6:0] OP_BREQ = 7'b0010010;
  localparam logic [6:0] OP_BRNE = 7'b0010011;
  localparam logic [6:0] OP_BRCS = 7'b0010100;
  localparam logic [6:0] OP_BRCC = 7'b0010101;

  typedef logic [1:0] bht_ctr_t;

  // Weak not-taken, so a fresh entry flips to taken after a single taken outcome.
  localparam bht_ctr_t BHT_CTR_INIT = 2'b01;

  function automatic logic [6:0] get_opcode(input logic [17:0] instr);
    return {instr[17:13], instr[1:0]};
  endfunction

  function automatic logic is_uncond_br(input logic [17:0] instr);
    logic [6:0] op;
    op = get_opcode(instr);
    return (op == OP_BRN) || (op == OP_CALL);
  endfunction

  function automatic logic is_cond_br(input logic [17:0] instr);
    logic [6:0] op;
    op = get_opcode(instr);
    return (op == OP_BREQ) || (op == OP_BRNE) || (op == OP_BRCS) || (op == OP_BRCC);
  endfunction

  function automatic logic [9:0] br_target(input logic [17:0] instr);
    return instr[12:3];
  endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: array of 2-bit saturating counters indexed by low PC bits.
// Latency: lookup is combinational; updates land at the clock edge (same-cycle lookup sees old value).
// Backpressure: none; updates are always accepted unless rst is high.
module fetch_bht
  import rat_fetch_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  bht_ctr_t ctr [ENTRIES];

  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= BHT_CTR_INIT;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
      end else begin
        if (ctr[upd_idx] != 2'b00) ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the PC, drives ROM address, predicts branches (BHT only with FETCH_BHT_EN).
// Latency: 1 cycle from redirect_valid to rom_addr == redirect_addr; prediction is same-cycle.
// Backpressure: stall holds the PC; a redirect overrides stall; BHT updates apply regardless.
module fetch_pc_unit
  import rat_fetch_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int INSTR_W   = 18,
  parameter int BHT_IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [INSTR_W-1:0] rom_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               upd_valid,
  input  logic [ADDR_W-1:0]  upd_pc,
  input  logic               upd_taken,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [ADDR_W-1:0]  alt_out,
  output logic               taken_out,
  output logic               squash_out
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;
  logic              cond_taken;
  logic              taken;
  logic [ADDR_W-1:0] alt;

  assign pc_inc = pc + 1'b1;  // wraps modulo 2^ADDR_W
  assign target = ADDR_W'(br_target(rom_instr));

`ifdef FETCH_BHT_EN
  bht_ctr_t                 bht_ctr;
  logic [ADDR_W-BHT_IDX_W-1:0] upd_pc_unused;

  assign upd_pc_unused = upd_pc[ADDR_W-1:BHT_IDX_W];

  fetch_bht #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pc[BHT_IDX_W-1:0]),
    .rd_ctr    (bht_ctr),
    .upd_valid (upd_valid),
    .upd_idx   (upd_pc[BHT_IDX_W-1:0]),
    .upd_taken (upd_taken)
  );

  assign cond_taken = bht_ctr[1];
`else
  logic upd_unused;

  assign upd_unused = ^{upd_valid, upd_pc, upd_taken};
  assign cond_taken = 1'b0;
`endif

  always_comb begin
    taken = 1'b0;
    alt   = pc_inc;
    if (is_uncond_br(rom_instr)) begin
      taken = 1'b1;
      alt   = pc_inc;
    end else if (is_cond_br(rom_instr)) begin
      taken = cond_taken;
      alt   = cond_taken ? pc_inc : target;
    end
  end

  always_comb begin
    next_pc = pc_inc;
    if (redirect_valid) begin
      next_pc = redirect_addr;
    end else if (stall) begin
      next_pc = pc;
    end else if (taken) begin
      next_pc = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else begin
      pc <= next_pc;
    end
  end

  assign rom_addr   = pc;
  assign addr_out   = pc;
  assign instr_out  = rom_instr;
  assign alt_out    = alt;
  assign taken_out  = taken;
  assign squash_out = redirect_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Table-driven bench for fetch_pc_unit with a small ROM model and an expected-output queue.
// Expectations for the trained-branch window depend on whether FETCH_BHT_EN is defined.
module tb_fetch_pc_unit;

`ifdef FETCH_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [17:0] rom_instr;
  logic        redirect_valid;
  logic [9:0]  redirect_addr;
  logic        upd_valid;
  logic [9:0]  upd_pc;
  logic        upd_taken;
  logic [9:0]  rom_addr;
  logic [17:0] instr_out;
  logic [9:0]  addr_out;
  logic [9:0]  alt_out;
  logic        taken_out;
  logic        squash_out;

  always #5 clk = ~clk;

  logic [17:0] rom [0:1023];
  assign rom_instr = rom[rom_addr];

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .rom_instr      (rom_instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .rom_addr       (rom_addr),
    .instr_out      (instr_out),
    .addr_out       (addr_out),
    .alt_out        (alt_out),
    .taken_out      (taken_out),
    .squash_out     (squash_out)
  );

  typedef struct {
    logic       rst;
    logic       stall;
    logic       rv;
    logic [9:0] ra;
    logic       uv;
    logic [9:0] up;
    logic       ut;
    logic [9:0] ea;
    logic       et;
    logic [9:0] ealt;
  } vec_t;

  typedef struct {
    logic [9:0] ea;
    logic       et;
    logic [9:0] ealt;
    logic       esq;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [17:0] mk(input logic [6:0] op, input logic [9:0] tgt);
    return {op[6:2], tgt, 1'b0, op[1:0]};
  endfunction

  function automatic void add(input logic r, input logic s, input logic rv, input logic [9:0] ra,
                              input logic uv, input logic [9:0] up, input logic ut,
                              input logic [9:0] ea, input logic et, input logic [9:0] ealt);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.ra = ra;
    v.uv = uv; v.up = up; v.ut = ut;
    v.ea = ea; v.et = et; v.ealt = ealt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) rom[a] = 18'h0;
    rom[5] = mk(7'b0010000, 10'h040);  // BRN 0x040
    rom[8] = mk(7'b0010010, 10'h100);  // BREQ 0x100

    //  rst st rv  ra      uv up  ut  exp_addr  tk  exp_alt
    add(1, 0, 0, 10'h0,   0, 0, 0,  10'h000,  0, 10'h001);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h000,  0, 10'h001);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h001,  0, 10'h002);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h002,  0, 10'h003);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h003,  0, 10'h004);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h004,  0, 10'h005);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h005,  1, 10'h006);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h040,  0, 10'h041);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h041,  0, 10'h042);
    // redirect wins over stall, then stall-only holds
    add(0, 1, 1, 10'h2AA, 0, 0, 0,  10'h042,  0, 10'h043);
    add(0, 1, 0, 10'h0,   0, 0, 0,  10'h2AA,  0, 10'h2AB);
    add(0, 1, 0, 10'h0,   0, 0, 0,  10'h2AA,  0, 10'h2AB);
    add(0, 1, 0, 10'h0,   0, 0, 0,  10'h2AA,  0, 10'h2AB);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h2AA,  0, 10'h2AB);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h2AB,  0, 10'h2AC);
    // wrap at top of address space
    add(0, 0, 1, 10'h3FE, 0, 0, 0,  10'h2AC,  0, 10'h2AD);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h3FE,  0, 10'h3FF);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h3FF,  0, 10'h000);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h000,  0, 10'h001);
    // mid-run reset at 0x123
    add(0, 0, 1, 10'h122, 0, 0, 0,  10'h001,  0, 10'h002);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h122,  0, 10'h123);
    add(1, 0, 0, 10'h0,   0, 0, 0,  10'h123,  0, 10'h124);
    add(0, 0, 1, 10'h008, 0, 0, 0,  10'h000,  0, 10'h001);
    // conditional branch at 8, fresh counter predicts not-taken
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h008,  0, 10'h100);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h009,  0, 10'h00A);
    add(0, 0, 1, 10'h008, 1, 8, 1,  10'h00A,  0, 10'h00B);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h008,  BHT, BHT ? 10'h009 : 10'h100);
    // four more taken updates, revisiting 8 each cycle
    add(0, 0, 1, 10'h008, 1, 8, 1,  BHT ? 10'h100 : 10'h009, 0, BHT ? 10'h101 : 10'h00A);
    add(0, 0, 1, 10'h008, 1, 8, 1,  10'h008,  BHT, BHT ? 10'h009 : 10'h100);
    add(0, 0, 1, 10'h008, 1, 8, 1,  10'h008,  BHT, BHT ? 10'h009 : 10'h100);
    add(0, 0, 1, 10'h008, 1, 8, 1,  10'h008,  BHT, BHT ? 10'h009 : 10'h100);
    // two not-taken updates: lookup in the update cycle still sees the old count
    add(0, 0, 1, 10'h008, 1, 8, 0,  10'h008,  BHT, BHT ? 10'h009 : 10'h100);
    add(0, 0, 1, 10'h008, 1, 8, 0,  10'h008,  BHT, BHT ? 10'h009 : 10'h100);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h008,  0, 10'h100);
    // train again, then reset with an update pending: counter returns to weak not-taken
    add(0, 0, 0, 10'h0,   1, 8, 1,  10'h009,  0, 10'h00A);
    add(1, 0, 0, 10'h0,   1, 8, 1,  10'h00A,  0, 10'h00B);
    add(0, 0, 1, 10'h008, 0, 0, 0,  10'h000,  0, 10'h001);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h008,  0, 10'h100);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h009,  0, 10'h00A);
    // stall with a taken branch in view holds pc
    add(0, 1, 1, 10'h005, 0, 0, 0,  10'h00A,  0, 10'h00B);
    add(0, 1, 0, 10'h0,   0, 0, 0,  10'h005,  1, 10'h006);
    add(0, 1, 0, 10'h0,   0, 0, 0,  10'h005,  1, 10'h006);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h005,  1, 10'h006);
    add(0, 0, 0, 10'h0,   0, 0, 0,  10'h040,  0, 10'h041);

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      rst            = tbl[i].rst;
      stall          = tbl[i].stall;
      redirect_valid = tbl[i].rv;
      redirect_addr  = tbl[i].ra;
      upd_valid      = tbl[i].uv;
      upd_pc         = tbl[i].up;
      upd_taken      = tbl[i].ut;
      exp_q.push_back('{ea: tbl[i].ea, et: tbl[i].et, ealt: tbl[i].ealt, esq: tbl[i].rv});
      #2;
      e = exp_q.pop_front();
      chk("rom_addr",   i, 32'(rom_addr),   32'(e.ea));
      chk("addr_out",   i, 32'(addr_out),   32'(e.ea));
      chk("instr_out",  i, 32'(instr_out),  32'(rom[e.ea]));
      chk("taken_out",  i, 32'(taken_out),  32'(e.et));
      chk("alt_out",    i, 32'(alt_out),    32'(e.ealt));
      chk("squash_out", i, 32'(squash_out), 32'(e.esq));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
